// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
package uart_rx_pkg;

   // Receiver FSM states, one per frame field
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   // Supported oversampling ratios
   localparam int PRESCALE_8  = 8;
   localparam int PRESCALE_16 = 16;
   localparam int PRESCALE_32 = 32;

   // Parity type encodings on par_typ
   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   // 2-of-3 vote used to reject a single noisy sample within a bit
   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and 3-sample majority voter for the UART receiver.
// edge_cnt runs 0..prescale-1 across each bit period; the bit value is the
// majority of the line at counts prescale/2-1, prescale/2 and prescale/2+1.
module uart_rx_sampler
   import uart_rx_pkg::*;
#(
   parameter int PRESCALE_W = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  start,
   input  logic                  active,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  rx_in,
   output logic                  sampled_bit,
   output logic                  bit_done
);

   logic [PRESCALE_W-1:0] edge_cnt;
   logic [PRESCALE_W-1:0] half;
   logic [PRESCALE_W-1:0] last;
   logic                  s0;
   logic                  s1;

   assign half     = prescale >> 1;
   assign last     = prescale - PRESCALE_W'(1);
   assign bit_done = active && (edge_cnt == last);

   // Edge counter: the cycle that detects the start edge is edge 0, so the
   // counter is loaded with 1 for the following cycle
   always_ff @(posedge CLK) begin
      if (RST || !(start || active)) begin
         edge_cnt <= '0;
      end else if (start) begin
         edge_cnt <= PRESCALE_W'(1);
      end else if (edge_cnt == last) begin
         edge_cnt <= '0;
      end else begin
         edge_cnt <= edge_cnt + PRESCALE_W'(1);
      end
   end

   // Capture the two early mid-bit samples and register the vote on the third
   always_ff @(posedge CLK) begin
      if (RST) begin
         s0          <= 1'b1;
         s1          <= 1'b1;
         sampled_bit <= 1'b1;
      end else if (active) begin
         if (edge_cnt == half - PRESCALE_W'(1)) begin
            s0 <= rx_in;
         end
         if (edge_cnt == half) begin
            s1 <= rx_in;
         end
         if (edge_cnt == half + PRESCALE_W'(1)) begin
            sampled_bit <= majority3(s0, s1, rx_in);
         end
      end
   end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: start-bit qualification, LSB-first deserialization,
// optional parity check and stop check, one parallel word per frame.
module uart_rx_core
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE_W = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  rx_in,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  par_en,
   input  logic                  par_typ,
   output logic [DATA_WIDTH-1:0] p_data,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err
);

   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [IDX_W-1:0] BIT_LAST = IDX_W'(DATA_WIDTH - 1);

   rx_state_t             state;
   logic [PRESCALE_W-1:0] prescale_q;
   logic                  par_en_q;
   logic                  par_typ_q;
   logic [IDX_W-1:0]      bit_idx;
   logic [DATA_WIDTH-1:0] shift;
   logic                  par_bad;

   logic                  start;
   logic                  active;
   logic                  sampled_bit;
   logic                  bit_done;

   assign start  = (state == IDLE) && !rx_in;
   assign active = (state != IDLE);

   uart_rx_sampler #(
      .PRESCALE_W (PRESCALE_W)
   ) u_sampler (
      .CLK         (CLK),
      .RST         (RST),
      .start       (start),
      .active      (active),
      .prescale    (prescale_q),
      .rx_in       (rx_in),
      .sampled_bit (sampled_bit),
      .bit_done    (bit_done)
   );

   // Frame FSM with deserializer, checkers and registered result strobes
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         prescale_q <= '0;
         par_en_q   <= 1'b0;
         par_typ_q  <= PAR_EVEN;
         bit_idx    <= '0;
         shift      <= '0;
         par_bad    <= 1'b0;
         p_data     <= '0;
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
         case (state)
            IDLE: begin
               if (!rx_in) begin
                  // Frame configuration is frozen here for the whole frame
                  state      <= START;
                  prescale_q <= prescale;
                  par_en_q   <= par_en;
                  par_typ_q  <= par_typ;
                  bit_idx    <= '0;
                  par_bad    <= 1'b0;
               end
            end
            START: begin
               if (bit_done) begin
                  // A start bit that votes high was a glitch: drop it silently
                  state <= sampled_bit ? IDLE : DATA;
               end
            end
            DATA: begin
               if (bit_done) begin
                  shift <= {sampled_bit, shift[DATA_WIDTH-1:1]};
                  if (bit_idx == BIT_LAST) begin
                     bit_idx <= '0;
                     state   <= par_en_q ? PARITY : STOP;
                  end else begin
                     bit_idx <= bit_idx + IDX_W'(1);
                  end
               end
            end
            PARITY: begin
               if (bit_done) begin
                  par_bad <= sampled_bit != ((^shift) ^ (par_typ_q == PAR_ODD));
                  state   <= STOP;
               end
            end
            STOP: begin
               if (bit_done) begin
                  state <= IDLE;
                  if (par_bad || !sampled_bit) begin
                     par_err <= par_bad;
                     stp_err <= !sampled_bit;
                  end else begin
                     p_data     <= shift;
                     data_valid <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
